// File: rtl/dct_transpose.sv
//------------------------------------------------------------------------------
// dct_transpose : 8x8 transpose buffer between row-pass and column-pass DCT.
// Optional ping-pong (two-bank) storage enabled by macro TRANSPOSE_PINGPONG_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dct_transpose #(
  parameter int W = 9
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [8*W-1:0] in_row,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [8*W-1:0] out_col,
  output logic [2:0]     out_col_idx,
  output logic           out_last
);

  logic [W-1:0] r_mem [0:1][0:7][0:7];
  logic [1:0]   r_full;
  logic         r_wr_bank;
  logic         r_rd_bank;
  logic [2:0]   r_wr_row;
  logic [2:0]   r_rd_col;

  logic w_wr_fire;
  logic w_rd_fire;
  logic w_wr_done;
  logic w_rd_done;
  logic w_wr_bank_nxt;
  logic w_rd_bank_nxt;

`ifdef TRANSPOSE_PINGPONG_EN
  assign w_wr_bank_nxt = ~r_wr_bank;
  assign w_rd_bank_nxt = ~r_rd_bank;
`else
  assign w_wr_bank_nxt = 1'b0;
  assign w_rd_bank_nxt = 1'b0;
`endif

  assign in_ready    = ~r_full[r_wr_bank];
  assign out_valid   = r_full[r_rd_bank];
  assign out_col_idx = r_rd_col;
  assign out_last    = out_valid && (r_rd_col == 3'd7);

  assign w_wr_fire = in_valid && in_ready;
  assign w_rd_fire = out_valid && out_ready;
  assign w_wr_done = w_wr_fire && (r_wr_row == 3'd7);
  assign w_rd_done = w_rd_fire && (r_rd_col == 3'd7);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_full    <= 2'b00;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_wr_row  <= 3'd0;
      r_rd_col  <= 3'd0;
    end else begin
      if (w_wr_fire) r_wr_row <= r_wr_row + 3'd1;
      if (w_wr_done) r_wr_bank <= w_wr_bank_nxt;
      if (w_rd_fire) r_rd_col <= r_rd_col + 3'd1;
      if (w_rd_done) r_rd_bank <= w_rd_bank_nxt;
      // A bank cannot be completed and drained in the same cycle, so set/clear never collide.
      for (int b = 0; b < 2; b++) begin
        if (w_wr_done && (r_wr_bank == 1'(b)))
          r_full[b] <= 1'b1;
        else if (w_rd_done && (r_rd_bank == 1'(b)))
          r_full[b] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_fire) begin
      for (int c = 0; c < 8; c++)
        r_mem[r_wr_bank][r_wr_row][c] <= in_row[(8-c)*W-1 -: W];
    end
  end

  always_comb begin
    out_col = '0;
    if (out_valid) begin
      for (int i = 0; i < 8; i++)
        out_col[(8-i)*W-1 -: W] = r_mem[r_rd_bank][i][r_rd_col];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dct_transpose.sv
//------------------------------------------------------------------------------
// tb_dct_transpose : scoreboard bench for dct_transpose.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_dct_transpose;

  localparam int W = 9;

  typedef struct packed {
    logic [8*W-1:0] col;
    logic [2:0]     idx;
    logic           last;
  } exp_t;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [8*W-1:0] in_row;
  logic           out_valid;
  logic           out_ready;
  logic [8*W-1:0] out_col;
  logic [2:0]     out_col_idx;
  logic           out_last;

  exp_t       q[$];
  logic [W-1:0] blk [8][8];
  int         checks = 0;
  int         errors = 0;
  int         stalls = 0;

  dct_transpose #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
    .out_valid(out_valid), .out_ready(out_ready), .out_col(out_col),
    .out_col_idx(out_col_idx), .out_last(out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [8*W-1:0] act, input logic [8*W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [8*W-1:0] row_of(input int r);
    logic [8*W-1:0] v;
    for (int c = 0; c < 8; c++) v[(8-c)*W-1 -: W] = blk[r][c];
    return v;
  endfunction

  function automatic logic [8*W-1:0] col_of(input int j);
    logic [8*W-1:0] v;
    for (int i = 0; i < 8; i++) v[(8-i)*W-1 -: W] = blk[i][j];
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_row(input logic [8*W-1:0] row);
    logic acc;
    int   n;
    n = 0;
    in_valid = 1'b1;
    in_row   = row;
    do begin
      @(negedge clk);
      acc = in_ready;
      if (!acc) stalls++;
      step();
      n++;
    end while (!acc && n < 200);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_row: in_ready stuck low, got 0 expected 1");
    end
    in_valid = 1'b0;
  endtask

  task automatic send_block();
    exp_t e;
    for (int r = 0; r < 8; r++) send_row(row_of(r));
    for (int j = 0; j < 8; j++) begin
      e.col  = col_of(j);
      e.idx  = 3'(j);
      e.last = (j == 7);
      q.push_back(e);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 500) begin
      step();
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d columns outstanding, expected 0", q.size());
    end
    step();
    chk("idle_out_valid", {71'b0, out_valid}, 72'd0);
  endtask

  // Monitor: every output handshake must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_col: got idx %0d col %h, expected no output", out_col_idx, out_col);
      end else begin
        e = q.pop_front();
        if (out_col !== e.col || out_col_idx !== e.idx || out_last !== e.last) begin
          errors++;
          $display("FAIL col_%0d: got col %h idx %0d last %0d expected col %h idx %0d last %0d",
                   e.idx, out_col, out_col_idx, out_last, e.col, e.idx, e.last);
        end
      end
    end
  end

  initial begin
    logic [8*W-1:0] ref_col;
    rst = 1'b1; in_valid = 1'b1; in_row = {8{9'h055}}; out_ready = 1'b1;

    // 1. reset with in_valid high
    step(); step();
    @(negedge clk);
    chk("rst_in_ready",  {71'b0, in_ready},  72'd1);
    chk("rst_out_valid", {71'b0, out_valid}, 72'd0);
    chk("rst_out_col",   out_col,            72'd0);
    chk("rst_col_idx",   {69'b0, out_col_idx}, 72'd0);
    chk("rst_out_last",  {71'b0, out_last},  72'd0);
    step();
    rst = 1'b0; in_valid = 1'b0;
    step();

    // 2. single block, element = r*8+c
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) blk[r][c] = W'(r*8 + c);
    out_ready = 1'b0;
    send_block();
    chk("latency_out_valid", {71'b0, out_valid}, 72'd1);
    for (int i = 0; i < 8; i++) ref_col[(8-i)*W-1 -: W] = W'(i*8);
    chk("first_col_direct", out_col, ref_col);
    out_ready = 1'b1;
    drain();

    // 3. backpressure on column 3
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) blk[r][c] = W'(200 + r*8 + c);
    out_ready = 1'b0;
    send_block();
    out_ready = 1'b1;
    step(); step(); step();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_col",  out_col, col_of(3));
      chk("stall_idx",  {69'b0, out_col_idx}, 72'd3);
      chk("stall_last", {71'b0, out_last}, 72'd0);
      step();
    end
    out_ready = 1'b1;
    drain();

    // 4. three blocks back-to-back
    stalls = 0;
    for (int k = 0; k < 3; k++) begin
      for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) blk[r][c] = W'(k*37 + r*8 + c + 7);
      send_block();
    end
`ifdef TRANSPOSE_PINGPONG_EN
    chk("stream_stalls", 72'(stalls), 72'd0);
`else
    chk("stream_stalls", 72'(stalls), 72'd16);
`endif
    drain();

    // 5. signed extremes in column 5
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) blk[r][c] = W'(100 + r*8 + c);
    blk[0][5] = 9'h1FF;
    blk[3][5] = 9'h100;
    blk[7][5] = 9'h0FF;
    send_block();
    drain();

    // 6. reset after 5 rows, then a fresh block
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) blk[r][c] = 9'h0AA;
    for (int r = 0; r < 5; r++) send_row(row_of(r));
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("midrst_out_valid", {71'b0, out_valid}, 72'd0);
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) blk[r][c] = W'(300 + c*8 + r);
    send_block();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/dct_transpose.md
Name: dct_transpose

Overview:
- Transpose buffer between the row-pass 1-D DCT and the column-pass 1-D DCT of the JPEG 8x8 forward transform.
- Accepts eight row-DCT output words of 8 packed signed coefficients each, forming one 8x8 block.
- Emits the block column by column in the same packed format, ready to feed the second DCT pass.
- Valid/ready handshake on both sides.

Parameters:
W, 9, signed coefficient width per element; row and column words are 8*W bits.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
in_valid  input  1  in_row holds a valid row
in_ready  output  1  block can accept a row this cycle
in_row  input  8*W  packed row; element 0 at [8W-1:7W], element 7 at [W-1:0]
out_valid  output  1  out_col holds a valid column
out_ready  input  1  consumer accepts out_col this cycle
out_col  output  8*W  packed column j; row 0's element j at [8W-1:7W], row 7's at [W-1:0]
out_col_idx  output  3  index j of the column on out_col
out_last  output  1  high with out_valid when out_col_idx==7

Behaviour:
- Reset values: in_ready=1, out_valid=0, out_last=0, out_col_idx=0, out_col=0.
  - Reset clears all bank-full flags and the write/read row, column and bank pointers.
  - Coefficient storage is not reset.
- Storage: two banks (see Optional Feature), each 8 rows x 8 elements x W bits.
- Write side:
  - A row is accepted when in_valid && in_ready.
  - The accepted row is stored at wr_row of bank wr_bank, then wr_row increments.
  - Accepting wr_row==7 sets full[wr_bank], toggles wr_bank and wraps wr_row to 0.
  - in_ready = !full[wr_bank], registered state only; no combinational path from out_ready.
- Read side:
  - out_valid = full[rd_bank].
  - out_col = element rd_col of rows 0..7 of bank rd_bank, packed as above.
  - out_col_idx = rd_col.
  - On out_valid && out_ready, rd_col increments.
  - Handshake at rd_col==7 clears full[rd_bank], toggles rd_bank and wraps rd_col to 0.
- Latency: out_valid rises the cycle after the 8th row of a block is accepted.
- Ordering: blocks are output strictly in arrival order; columns are output in order 0..7.
- Stalls:
  - While out_valid && !out_ready, out_col, out_col_idx and out_last hold stable.
  - in_valid low between rows simply pauses wr_row; any gap length is allowed.
- Simultaneous events:
  - Completing a write into one bank and freeing the other bank in the same cycle applies both updates.
  - A bank freed in cycle t may be written from cycle t+1 (in_ready rises at t+1).
- Arithmetic: pure data movement. Elements are stored and output bit-exact, with no sign extension or rounding.
- Output while out_valid=0: out_col=0, out_last=0.
- Reset mid-block: discards partial rows and any full banks. The next accepted row is row 0 of a new block.

Optional Feature:
- Macro TRANSPOSE_PINGPONG_EN.
- Defined: two banks as described; sustained throughput is one block per 8 cycles with in_valid and out_ready held high. in_ready never drops in that steady state.
- Undefined:
  - Single bank; wr_bank and rd_bank are always 0.
  - in_ready=0 from the cycle after the 8th row is accepted until the cycle after column 7 is accepted.
  - Throughput is one block per 16 cycles.
  - Handshake and output formats are unchanged.

Test Plan:
1. Reset: assert rst 2 cycles with in_valid=1 -> in_ready=1, out_valid=0, out_col=0, out_col_idx=0. No row is counted during reset.
2. Single block: row r element c = r*8+c, rows sent back-to-back, out_ready=1 -> out_valid rises the cycle after row 7. Column j element i = i*8+j; out_col_idx steps 0..7; out_last only on column 7.
3. Backpressure: drop out_ready for 5 cycles while column 3 is shown -> out_col and out_col_idx=3 stay stable. Columns 4..7 follow with none skipped or repeated.
4. Streaming, 3 blocks back-to-back (24 rows, out_ready=1):
   - Macro on: in_ready stays 1 for all 24 rows; 24 columns match the transposes.
   - Macro off: in_ready low for 8 cycles after each block.
5. Signed values: elements 0x1FF (-1), 0x100 (-256) and 0x0FF (255) in rows 0, 3 and 7 of column 5 -> column 5 reproduces them bit-exact at the corresponding positions.
6. Reset mid-block: rst after 5 rows, then a fresh 8-row block -> output contains only the fresh block; no stale rows appear.
